fifo_drain_ctrl: RTL

Read-side controller for the on-board FIFO demo. It pops one FIFO entry per read tick, or back-to-back in drain mode, and captures the word. It presents the word downstream on a valid/ready handshake and reports burst completion and read activity for status LEDs. It sits between the FIFO read port (`rd_en`, `dout`, `empty`) and the PMOD/LED output logic. It is the consumer counterpart of the timed switch-data writer.

---
 rtl/fifo_demo_pkg.sv | 12 +
 rtl/tick_gen.sv | 17 +
 rtl/fifo_drain_ctrl.sv | 66 ++++++
 3 files changed

// File: rtl/fifo_demo_pkg.sv
// fifo_demo_pkg: shared FSM encoding and timer defaults for the FIFO demo
package fifo_demo_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        POP  = 3'd2,
        CAPT = 3'd3,
        HOLD = 3'd4
    } drain_state_e;
    localparam int TICK_DIV_1S = 100_000_000;
    localparam int TICK_DIV_2S = 200_000_000;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running interval counter, one-cycle tick every DIV cycles while enabled
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] tcnt;
    assign tick = tcnt == W'(DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || !en) tcnt <= '0;
        else               tcnt <= tick ? '0 : tcnt + 1'b1;
    end
endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: FIFO read-side controller, timed or drain pops onto a valid/ready output
module fifo_drain_ctrl
    import fifo_demo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TICK_DIV  = TICK_DIV_2S,
    parameter int BURST_LEN = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              drain,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              burst_done,
    output logic [CNT_W-1:0]  pop_count,
    output logic              busy
);
    localparam int BW = $clog2(BURST_LEN + 1);
    drain_state_e state, nxt;
    logic [BW-1:0] bcnt;
    logic tick, hs;
    tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .en(run), .tick(tick));
    assign hs   = state == HOLD && m_valid && m_ready;
    assign busy = state == POP || state == CAPT || state == HOLD;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = run ? WAIT : IDLE;
            WAIT:    nxt = !run ? IDLE : ((tick || drain) && !fifo_empty) ? POP : WAIT;
            POP:     nxt = CAPT;
            CAPT:    nxt = HOLD;
            HOLD:    nxt = !hs ? HOLD : run ? WAIT : IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            burst_done <= 1'b0;
            bcnt       <= '0;
            pop_count  <= '0;
        end else begin
            state      <= nxt;
            fifo_rd_en <= nxt == POP;
            burst_done <= hs && bcnt == BW'(BURST_LEN - 1);
            if (state == CAPT) begin
                m_data  <= fifo_dout;
                m_valid <= 1'b1;
            end
            if (hs) begin
                m_valid   <= 1'b0;
                pop_count <= pop_count + 1'b1;
                bcnt      <= bcnt == BW'(BURST_LEN - 1) ? '0 : bcnt + 1'b1;
            end
        end
    end
endmodule
